// File: rtl/seq_divider_pkg.sv
// Shared adder/divider constants: carry-in polarity for the ripple adder,
// divider FSM encoding and the default operand width.
package seq_divider_pkg;

  localparam logic ADDER_CIN_SUB     = 1'b1;
  localparam int   DIV_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_rca.sv
// Plain ripple-carry adder; the divider uses it as a subtractor (a + ~b + 1).
module ripply_carry_adder #(
  parameter int width = 4
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] sum,
  output logic             cout
);

  logic [width:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < width; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[width];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first,
// with back-to-back starts accepted in the DONE cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int width = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [width-1:0] dvd;
  logic [width-1:0] dvs;
  logic [width-1:0] rem;
  logic [width-2:0] qacc;

  logic [width:0]   shifted;
  logic [width:0]   trial;
  logic             cout;
  logic             borrow;
  logic [width-1:0] next_rem;
  logic [width-1:0] next_q;

  assign shifted = {rem, dvd[width-1]};

  ripply_carry_adder #(.width(width + 1)) u_sub (
    .a    (shifted),
    .b    (~{1'b0, dvs}),
    .cin  (ADDER_CIN_SUB),
    .sum  (trial),
    .cout (cout)
  );

  // Sign bit and carry-out agree here; either one flags a negative trial.
  assign borrow   = trial[width] | ~cout;
  assign next_rem = borrow ? shifted[width-1:0] : trial[width-1:0];
  assign next_q   = {qacc, ~borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      qacc        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dvd         <= a;
            dvs         <= b;
            rem         <= '0;
            qacc        <= '0;
            count       <= CW'(width - 1);
            div_by_zero <= 1'b0;
            if (b == '0) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          dvd  <= dvd << 1;
          rem  <= next_rem;
          qacc <= next_q[width-2:0];
          if (count == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= next_q;
            remainder <= next_rem;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (width 4): directed scenarios plus all
// 256 operand pairs in shuffled back-to-back order against plain / and %.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests_run = 0;
  int tests_failed = 0;

  seq_divider #(.width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done shows, giving up after 40 so callers see a bad latency.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int c;
    rst_n = 1'b0;
    start = 1'b0;
    #2;
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got busy=%b done=%b dbz=%b expected 0 0 0", busy, done, div_by_zero);
    end
    tests_run++;
    if (quotient !== 4'd0 || remainder !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got q=%0d r=%0d expected 0 0", quotient, remainder);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a = 4'd6;
    b = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL first_start: got busy=%b expected 1", busy);
    end
    wait_done(c);
    tests_run++;
    if (c !== 4 || quotient !== 4'd2 || remainder !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL first_op: got lat=%0d q=%0d r=%0d expected 4 2 0", c, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_basic();
    a = 4'd13;
    b = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL basic_busy[%0d]: got busy=%b done=%b expected 1 0", i, busy, done);
      end
      tick();
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 4'd3 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_result: got done=%b busy=%b q=%0d r=%0d dbz=%b expected 1 0 3 1 0",
               done, busy, quotient, remainder, div_by_zero);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || quotient !== 4'd3 || remainder !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL basic_hold: got done=%b q=%0d r=%0d expected 0 3 1", done, quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    a = 4'd9;
    b = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 4'd15 || remainder !== 4'd9 || div_by_zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL div_zero: got done=%b busy=%b q=%0d r=%0d dbz=%b expected 1 0 15 9 1",
               done, busy, quotient, remainder, div_by_zero);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL div_zero_after: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    a = 4'd15;
    b = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c1);
    tests_run++;
    if (c1 !== 4 || quotient !== 4'd15 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got lat=%0d q=%0d r=%0d dbz=%b expected 4 15 0 0",
               c1, quotient, remainder, div_by_zero);
    end
    a = 4'd0;
    b = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_no_bubble: got busy=%b done=%b expected 1 0", busy, done);
    end
    wait_done(c2);
    tests_run++;
    if (c2 !== 4 || quotient !== 4'd0 || remainder !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got lat=%0d q=%0d r=%0d expected 4 0 0", c2, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int c;
    int extra;
    a = 4'd14;
    b = 4'd3;
    start = 1'b1;
    tick();
    a = 4'd2;
    b = 4'd2;
    tick();
    start = 1'b0;
    wait_done(c);
    tests_run++;
    if (c !== 3 || quotient !== 4'd4 || remainder !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL ignore_start: got lat=%0d q=%0d r=%0d expected 3 4 2", c, quotient, remainder);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ignore_start_single_done: got %0d extra dones expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int c;
    int dones;
    a = 4'd12;
    b = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 4'd0 || remainder !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset: got busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_abort: got %0d active cycles expected 0", dones);
    end
    a = 4'd12;
    b = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c);
    tests_run++;
    if (c !== 4 || quotient !== 4'd2 || remainder !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL midrun_restart: got lat=%0d q=%0d r=%0d expected 4 2 2", c, quotient, remainder);
    end
    tick();
  endtask

  // Every pair once, shuffled, each start issued in the previous DONE cycle.
  task automatic test_exhaustive();
    int order[256];
    int tmp, j, c;
    int cur_a, cur_b, exp_q, exp_r, exp_lat;
    logic exp_z;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    cur_a = order[0] / 16;
    cur_b = order[0] % 16;
    a = 4'(cur_a);
    b = 4'(cur_b);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      wait_done(c);
      if (cur_b == 0) begin
        exp_q = 15;
        exp_r = cur_a;
        exp_z = 1'b1;
        exp_lat = 0;
      end else begin
        exp_q = cur_a / cur_b;
        exp_r = cur_a % cur_b;
        exp_z = 1'b0;
        exp_lat = W;
      end
      tests_run++;
      if (done !== 1'b1 || quotient !== 4'(exp_q) || remainder !== 4'(exp_r) || div_by_zero !== exp_z) begin
        tests_failed++;
        $display("[TB] FAIL div a=%0d b=%0d: got done=%b q=%0d r=%0d dbz=%b expected 1 %0d %0d %b",
                 cur_a, cur_b, done, quotient, remainder, div_by_zero, exp_q, exp_r, exp_z);
      end
      tests_run++;
      if (c !== exp_lat) begin
        tests_failed++;
        $display("[TB] FAIL latency a=%0d b=%0d: got %0d expected %0d", cur_a, cur_b, c, exp_lat);
      end
      if (k < 255) begin
        cur_a = order[k+1] / 16;
        cur_b = order[k+1] % 16;
        a = 4'(cur_a);
        b = 4'(cur_b);
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
